// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen shared definitions: reset/exception vectors, bus widths,
// fetch FSM encoding and a word-alignment helper.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_PC       = 32'hBFC00000;
  localparam logic [31:0] EXC_ENTER_ADDR = 32'hBFC00380;

  localparam int EXC_BUS_W   = 33;  // {exc_valid, exc_pc}
  localparam int JBR_BUS_W   = 33;  // {br_taken, br_target}
  localparam int IF_ID_BUS_W = 65;  // {fetch_error, pc, inst}

  // S_HALT is only entered when the address check feature is built in.
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: instruction-memory request bus plus the IF->ID slot bus.
// master = fetch unit, slave = memory / decode side.
interface fetch_pc_gen_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        IF_valid;
  logic        ID_allowin;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        IF_fetch_error;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output IF_valid, IF_pc, IF_inst, IF_fetch_error,
    input  ID_allowin
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  IF_valid, IF_pc, IF_inst, IF_fetch_error,
    output ID_allowin
  );

endinterface

// File: rtl/fetch_slot_buf.sv
// fetch_slot_buf: single-entry IF output register with valid/allowin
// handshake and an exception flush.
module fetch_slot_buf
  import fetch_pc_gen_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill,
  input  logic [IF_ID_BUS_W-1:0] fill_data,
  input  logic                   flush,
  input  logic                   allowin,
  output logic                   valid,
  output logic [IF_ID_BUS_W-1:0] data
);

  // Occupancy: flush beats fill, fill beats consumption by ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               valid <= 1'b0;
    else if (flush)          valid <= 1'b0;
    else if (fill)           valid <= 1'b1;
    else if (valid && allowin) valid <= 1'b0;
  end

  // Payload only moves on a fill, so a stalled slot stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              data <= '0;
    else if (fill && !flush) data <= fill_data;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: PC generator and single-outstanding instruction fetch.
// Optional build macro FETCH_ADDR_CHECK_EN: a misaligned pc_r raises an
// address-error slot instead of a memory request.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = fetch_pc_gen_pkg::RESET_PC
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [fetch_pc_gen_pkg::EXC_BUS_W-1:0] exc_bus,
  input  logic [fetch_pc_gen_pkg::JBR_BUS_W-1:0] jbr_bus,
  fetch_pc_gen_if.master                        fi
);
  import fetch_pc_gen_pkg::*;

  logic                   exc_valid, br_taken;
  logic [31:0]            exc_pc, br_target;
  fetch_state_t           state;
  logic                   armed;
  logic [31:0]            pc_r, req_pc, redirect_pc;
  logic                   redirect_pend;
  logic                   slot_valid, slot_free, br_now, can_issue;
  logic                   pc_misaligned, data_fill, err_fill;
  logic [IF_ID_BUS_W-1:0] fill_data, slot_data;
  logic [31:0]            next_pc;

  assign {exc_valid, exc_pc}   = exc_bus;
  assign {br_taken, br_target} = jbr_bus;

  // A request may only start if its result will have somewhere to land.
  assign slot_free = !slot_valid || fi.ID_allowin;
  // Branch seen in REQ with the delay slot already in the slot: pc_r is
  // past the delay slot, so retarget now rather than fetch pc_r.
  assign br_now    = br_taken && slot_valid;

`ifdef FETCH_ADDR_CHECK_EN
  assign pc_misaligned = (pc_r[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  assign can_issue    = armed && (state == S_REQ) && slot_free && !exc_valid && !br_now;
  assign fi.inst_req  = can_issue && !pc_misaligned;
  assign fi.inst_addr = word_addr(pc_r);

  // Killed data (same-cycle exception) never reaches the slot.
  assign data_fill = (state == S_WAIT) && fi.inst_data_ok && !exc_valid;
  assign err_fill  = can_issue && pc_misaligned;
  assign fill_data = err_fill ? {1'b1, pc_r, 32'd0} : {1'b0, req_pc, fi.inst_rdata};

  // Sequential successor after a returned instruction (delay slot aware).
  assign next_pc = br_taken      ? br_target   :
                   redirect_pend ? redirect_pc :
                                   pc_r + 32'd4;

  // Fetch FSM: pc tracking, pending branch, outstanding-request bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_REQ;
      armed         <= 1'b0;
      pc_r          <= RESET_PC;
      req_pc        <= '0;
      redirect_pend <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_REQ: begin
          if (exc_valid) begin
            pc_r          <= exc_pc;
            redirect_pend <= 1'b0;
          end else begin
            if (br_taken) begin
              if (slot_valid) begin
                pc_r          <= br_target;
                redirect_pend <= 1'b0;
              end else begin
                redirect_pend <= 1'b1;
                redirect_pc   <= br_target;
              end
            end
            if (fi.inst_req && fi.inst_addr_ok) begin
              req_pc <= pc_r;
              state  <= S_WAIT;
            end
            if (err_fill) state <= S_HALT;
          end
        end
        S_WAIT: begin
          if (exc_valid) begin
            pc_r          <= exc_pc;
            redirect_pend <= 1'b0;
            state         <= fi.inst_data_ok ? S_REQ : S_DISCARD;
          end else if (fi.inst_data_ok) begin
            pc_r          <= next_pc;
            redirect_pend <= 1'b0;
            state         <= S_REQ;
          end else if (br_taken) begin
            redirect_pend <= 1'b1;
            redirect_pc   <= br_target;
          end
        end
        S_DISCARD: begin
          if (exc_valid)       pc_r  <= exc_pc;
          if (fi.inst_data_ok) state <= S_REQ;
        end
        S_HALT: begin
          if (exc_valid) begin
            pc_r          <= exc_pc;
            redirect_pend <= 1'b0;
            state         <= S_REQ;
          end else if (br_taken) begin
            pc_r  <= br_target;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  fetch_slot_buf u_slot (
    .clk       (clk),
    .reset     (reset),
    .fill      (data_fill || err_fill),
    .fill_data (fill_data),
    .flush     (exc_valid),
    .allowin   (fi.ID_allowin),
    .valid     (slot_valid),
    .data      (slot_data)
  );

  assign fi.IF_valid       = slot_valid;
  assign fi.IF_fetch_error = slot_data[64];
  assign fi.IF_pc          = slot_data[63:32];
  assign fi.IF_inst        = slot_data[31:0];

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- PC generator and instruction-fetch front end for the five-stage pipeline.
- Receives the exception/ERET redirect bus driven by the write-back stage and the branch redirect from decode.
- Issues single-outstanding requests to instruction memory and hands {pc, inst, fetch_error} to the IF→ID bus under a valid/allowin handshake.
- Discards in-flight fetches that a redirect has killed.

Parameters:
- RESET_PC, 32'hBFC00000, PC fetched first after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- exc_bus  in  33  {exc_valid, exc_pc}; exc_valid is a single-cycle pulse that also implies cancel.
- jbr_bus  in  33  {br_taken, br_target}; qualified by ID valid upstream.
- inst_req  out  1  memory request valid.
- inst_addr  out  32  request address, word aligned.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  returned instruction.
- IF_valid  out  1  output slot holds a fetched instruction.
- ID_allowin  in  1  ID accepts the slot this cycle.
- IF_pc  out  32  PC of the slot.
- IF_inst  out  32  instruction of the slot.
- IF_fetch_error  out  1  slot carries an address-error exception (see optional feature).

Behaviour:
- Reset (async): pc_r=RESET_PC, state=REQ, slot empty, redirect_pend=0. Outputs: inst_req=0 until the first clock edge after reset deasserts, IF_valid=0, IF_pc=0, IF_inst=0, IF_fetch_error=0.
- Redirect priority: exc_valid > br_taken > sequential pc_r+4 (32-bit wrap, no carry out).
- Redirect on exc_valid: flush the output slot (IF_valid=0 next cycle) and load pc_r<=exc_pc.
- Redirect on br_taken: does not flush the slot; the slot already holds the delay-slot instruction.
- Exception during REQ, or WAIT with the request not yet accepted: the address changes immediately next cycle. inst_req may drop and re-raise with the new address.
- Slot rule: holds one entry. A new request is issued only when the slot is empty, or is being consumed this cycle (IF_valid & ID_allowin).
- State machine:
  - REQ: inst_req=1, inst_addr=pc_r. On inst_addr_ok go to WAIT and latch req_pc=pc_r.
  - WAIT: inst_req=0. On inst_data_ok, fill the slot {req_pc, inst_rdata}, advance pc_r per priority, go to REQ.
  - WAIT + exc_valid before data returns: go to DISCARD, latch the new pc.
  - DISCARD: inst_req=0. On inst_data_ok drop the data and go to REQ with the redirected pc.
- Same-cycle exc_valid and inst_data_ok in WAIT: data is dropped, no slot fill, go to REQ.
- Branch while WAIT: pending target stored in redirect_pend/redirect_pc and applied when data returns instead of pc_r+4. A later exc_valid overrides and clears redirect_pend.
- Fetch latency: minimum 2 cycles from request to IF_valid (accept cycle plus data cycle).
- Stall: when ID_allowin=0 and the slot is full, IF holds IF_pc/IF_inst stable and issues no request.
- Reset mid-transaction: any outstanding response arriving after reset is ignored. State is REQ, so inst_data_ok outside WAIT/DISCARD is ignored.

Optional Feature:
- Macro FETCH_ADDR_CHECK_EN.
- Defined: if pc_r[1:0]!=0, no memory request is issued. The slot fills in the next cycle with {pc_r, 32'd0, IF_fetch_error=1}, then the unit waits for a redirect; pc_r does not advance.
- Undefined: IF_fetch_error tied 0 and inst_addr={pc_r[31:2],2'b00}.

Decomposition:
- Shared package/header holds:
  - RESET_PC / EXC_ENTER_ADDR (32'hBFC00380) constants.
  - Bus width defines (EXC_BUS_W=33, JBR_BUS_W=33, IF_ID_BUS_W=65).
  - FSM state encoding REQ/WAIT/DISCARD.
- One natural sub-module, fetch_slot_buf: the single-entry output register with valid/allowin and flush.

Test Plan:
- Reset release, memory always ready → inst_addr BFC00000, BFC00004, BFC00008; IF_pc follows, one instruction per 2 cycles.
- exc_bus={1,BFC00380} while WAIT for BFC00010 → returned data dropped, IF_valid stays 0, next inst_addr=BFC00380.
- br_taken target 80001000 while WAIT → returning instruction (delay slot) delivered, next inst_addr=80001000.
- ID_allowin=0 for 5 cycles with slot full → IF_pc/IF_inst stable, inst_req=0; first allowin → request for pc+4.
- exc_valid same cycle as inst_data_ok → no IF_valid, exc_pc fetched next; reset asserted in WAIT → inst_req=0 immediately, restart at BFC00000.
- FETCH_ADDR_CHECK_EN, exc_pc=BFC00382 → no inst_req, IF_valid=1 with IF_fetch_error=1, IF_pc=BFC00382.
